// File: rtl/alu_sched_pkg.sv
// Shared types and helpers for the ALU scheduler: FSM states, op codes and
// the operand-byte sequencing used during the ALU load phase.
package alu_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        LOAD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    function automatic logic [1:0] load_bytes(input logic [1:0] op);
        if (op == OP_DIV) begin
            return 2'd3;
        end else begin
            return 2'd2;
        end
    endfunction

    // Divide sends a 16-bit dividend high byte first; everything else is x[7:0], y.
    function automatic logic [7:0] load_byte(input logic [1:0]  op,
                                             input logic [15:0] x,
                                             input logic [7:0]  y,
                                             input logic [1:0]  idx);
        logic [7:0] b;
        b = 8'h00;
        if (op == OP_DIV) begin
            case (idx)
                2'd0:    b = x[15:8];
                2'd1:    b = x[7:0];
                2'd2:    b = y;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                2'd0:    b = x[7:0];
                2'd1:    b = y;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/alu_scheduler_rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, pointer moves past the
// granted requester whenever the advance strobe reports a handshake.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_r;

    // Grant selection: contention resolved by the pointer, lone requester wins.
    always_comb begin
        grant = 2'b00;
        if (req == 2'b11) begin
            grant = ptr_r ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Pointer register: favour the requester that was not just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_r <= 1'b0;
        end else if (advance) begin
            ptr_r <= grant[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/alu_scheduler.sv
// Two-port arbitrated sequencer driving the ALU load/collect protocol.
// Optional WAIT timeout with ALU abort pulse: define ALU_SCHED_TIMEOUT_EN.
module alu_scheduler
    import alu_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [1:0]  r0_op,
    input  logic [15:0] r0_x,
    input  logic [7:0]  r0_y,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [1:0]  r1_op,
    input  logic [15:0] r1_x,
    input  logic [7:0]  r1_y,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic        rsp_error,
    output logic        alu_begin,
    output logic [1:0]  alu_op_code,
    output logic [7:0]  alu_inbus,
    input  logic [7:0]  alu_outbus,
    input  logic        alu_end,
    output logic        alu_reset
);

    state_t      state_r, state_nx;
    logic [1:0]  op_r, op_nx;
    logic [15:0] x_r, x_nx;
    logic [7:0]  y_r, y_nx;
    logic        id_r, id_nx;
    logic [1:0]  cnt_r, cnt_nx;
    logic [15:0] hist_r, hist_nx;
    logic        rsp_valid_nx, rsp_id_nx, rsp_error_nx;
    logic [15:0] rsp_result_nx;
    logic        begin_nx;
    logic [1:0]  op_code_nx;
    logic [7:0]  inbus_nx;
    logic [1:0]  gnt_s;
    logic        hs_s;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     ({r1_valid, r0_valid}),
        .advance (hs_s),
        .grant   (gnt_s)
    );

    assign r0_ready = r0_valid && (state_r == IDLE) && gnt_s[0];
    assign r1_ready = r1_valid && (state_r == IDLE) && gnt_s[1];
    assign hs_s     = r0_ready || r1_ready;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_r, tcnt_nx;
    logic          abort_nx, abort_r;
    assign alu_reset = abort_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign alu_reset        = 1'b0;
`endif

    // Next-state, operand latch, result formation and next output values.
    always_comb begin
        state_nx      = state_r;
        op_nx         = op_r;
        x_nx          = x_r;
        y_nx          = y_r;
        id_nx         = id_r;
        cnt_nx        = cnt_r;
        hist_nx       = hist_r;
        rsp_valid_nx  = 1'b0;
        rsp_id_nx     = 1'b0;
        rsp_error_nx  = 1'b0;
        rsp_result_nx = 16'h0000;
`ifdef ALU_SCHED_TIMEOUT_EN
        tcnt_nx       = tcnt_r;
        abort_nx      = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (hs_s) begin
                    id_nx = gnt_s[1];
                    op_nx = gnt_s[1] ? r1_op : r0_op;
                    x_nx  = gnt_s[1] ? r1_x  : r0_x;
                    y_nx  = gnt_s[1] ? r1_y  : r0_y;
                    if ((op_nx == OP_DIV) && (y_nx == 8'h00)) begin
                        state_nx      = DONE;
                        rsp_valid_nx  = 1'b1;
                        rsp_id_nx     = id_nx;
                        rsp_error_nx  = 1'b1;
                        rsp_result_nx = 16'hFFFF;
                    end else begin
                        state_nx = START;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                state_nx = LOAD;
                cnt_nx   = 2'd0;
`ifdef ALU_SCHED_TIMEOUT_EN
                tcnt_nx  = '0;
`endif
            end
            LOAD: begin
                if (cnt_r == (load_bytes(op_r) - 2'd1)) begin
                    state_nx = WAIT;
                end else begin
                    cnt_nx = cnt_r + 2'd1;
                end
            end
            WAIT: begin
                hist_nx = {hist_r[7:0], alu_outbus};
                if (alu_end) begin
                    state_nx      = DONE;
                    rsp_valid_nx  = 1'b1;
                    rsp_id_nx     = id_r;
                    rsp_result_nx = ((op_r == OP_ADD) || (op_r == OP_SUB)) ?
                                    {8'h00, alu_outbus} : {hist_r[7:0], alu_outbus};
                end else begin
`ifdef ALU_SCHED_TIMEOUT_EN
                    if (tcnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
                        state_nx     = DONE;
                        rsp_valid_nx = 1'b1;
                        rsp_id_nx    = id_r;
                        rsp_error_nx = 1'b1;
                        abort_nx     = 1'b1;
                    end else begin
                        tcnt_nx = tcnt_r + TW'(1);
                    end
`else
                    state_nx = WAIT;
`endif
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        begin_nx   = (state_nx == START);
        op_code_nx = ((state_nx == START) || (state_nx == LOAD) || (state_nx == WAIT)) ?
                     op_nx : 2'd0;
        inbus_nx   = (state_nx == LOAD) ? load_byte(op_nx, x_nx, y_nx, cnt_nx) : 8'h00;
    end

    // State, operand and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            op_r        <= 2'd0;
            x_r         <= 16'h0000;
            y_r         <= 8'h00;
            id_r        <= 1'b0;
            cnt_r       <= 2'd0;
            hist_r      <= 16'h0000;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_error   <= 1'b0;
            rsp_result  <= 16'h0000;
            alu_begin   <= 1'b0;
            alu_op_code <= 2'd0;
            alu_inbus   <= 8'h00;
`ifdef ALU_SCHED_TIMEOUT_EN
            tcnt_r      <= '0;
            abort_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx;
            op_r        <= op_nx;
            x_r         <= x_nx;
            y_r         <= y_nx;
            id_r        <= id_nx;
            cnt_r       <= cnt_nx;
            hist_r      <= hist_nx;
            rsp_valid   <= rsp_valid_nx;
            rsp_id      <= rsp_id_nx;
            rsp_error   <= rsp_error_nx;
            rsp_result  <= rsp_result_nx;
            alu_begin   <= begin_nx;
            alu_op_code <= op_code_nx;
            alu_inbus   <= inbus_nx;
`ifdef ALU_SCHED_TIMEOUT_EN
            tcnt_r      <= tcnt_nx;
            abort_r     <= abort_nx;
`endif
        end
    end

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed self-checking bench for alu_scheduler; the ALU side is driven by hand.
module tb_alu_scheduler;

`ifdef ALU_SCHED_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 255;
`endif

    logic        clk;
    logic        reset;
    logic        r0_valid, r0_ready, r1_valid, r1_ready;
    logic [1:0]  r0_op, r1_op;
    logic [15:0] r0_x, r1_x;
    logic [7:0]  r0_y, r1_y;
    logic        rsp_valid, rsp_id, rsp_error;
    logic [15:0] rsp_result;
    logic        alu_begin;
    logic [1:0]  alu_op_code;
    logic [7:0]  alu_inbus, alu_outbus;
    logic        alu_end, alu_reset;

    int total = 0;
    int bad   = 0;

    alu_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .r0_valid    (r0_valid),
        .r0_ready    (r0_ready),
        .r0_op       (r0_op),
        .r0_x        (r0_x),
        .r0_y        (r0_y),
        .r1_valid    (r1_valid),
        .r1_ready    (r1_ready),
        .r1_op       (r1_op),
        .r1_x        (r1_x),
        .r1_y        (r1_y),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_error   (rsp_error),
        .alu_begin   (alu_begin),
        .alu_op_code (alu_op_code),
        .alu_inbus   (alu_inbus),
        .alu_outbus  (alu_outbus),
        .alu_end     (alu_end),
        .alu_reset   (alu_reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_begin"}, {31'd0, alu_begin}, 32'd0);
        chk({tag, "_opc"},   {30'd0, alu_op_code}, 32'd0);
        chk({tag, "_inbus"}, {24'd0, alu_inbus}, 32'd0);
        chk({tag, "_rspv"},  {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rspr"},  {16'd0, rsp_result}, 32'd0);
        chk({tag, "_rspe"},  {31'd0, rsp_error}, 32'd0);
        chk({tag, "_rspid"}, {31'd0, rsp_id}, 32'd0);
        chk({tag, "_alurst"},{31'd0, alu_reset}, 32'd0);
    endtask

    initial begin
        int  n;
        logic seen;
        reset = 1'b1;
        r0_valid = 1'b0; r0_op = 2'd0; r0_x = 16'h0000; r0_y = 8'h00;
        r1_valid = 1'b0; r1_op = 2'd0; r1_x = 16'h0000; r1_y = 8'h00;
        alu_outbus = 8'h00; alu_end = 1'b0;
        #2;
        chk_all_zero("rst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_all_zero("post_rst");

        // r0 add 05 + 03, END on WAIT cycle 4
        r0_valid = 1'b1; r0_op = 2'd0; r0_x = 16'h0005; r0_y = 8'h03;
        #1;
        chk("add_r0_ready", {31'd0, r0_ready}, 32'd1);
        chk("add_r1_ready", {31'd0, r1_ready}, 32'd0);
        step(); r0_valid = 1'b0;
        chk("add_begin", {31'd0, alu_begin}, 32'd1);
        chk("add_start_inbus", {24'd0, alu_inbus}, 32'h00);
        step();
        chk("add_byte0", {24'd0, alu_inbus}, 32'h05);
        chk("add_begin_off", {31'd0, alu_begin}, 32'd0);
        step();
        chk("add_byte1", {24'd0, alu_inbus}, 32'h03);
        step();
        chk("add_wait_inbus", {24'd0, alu_inbus}, 32'h00);
        alu_outbus = 8'h11;
        step(); step();
        chk("add_wait_norsp", {31'd0, rsp_valid}, 32'd0);
        step();
        alu_outbus = 8'h08; alu_end = 1'b1;
        step();
        alu_end = 1'b0;
        chk("add_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("add_result", {16'd0, rsp_result}, 32'h0008);
        chk("add_id", {31'd0, rsp_id}, 32'd0);
        chk("add_err", {31'd0, rsp_error}, 32'd0);
        chk("add_alurst", {31'd0, alu_reset}, 32'd0);
        step();
        chk("add_rsp_once", {31'd0, rsp_valid}, 32'd0);

        // r1 mul 0C * 0B, ALU returns 00 then 84
        r1_valid = 1'b1; r1_op = 2'd2; r1_x = 16'h000C; r1_y = 8'h0B;
        #1;
        chk("mul_r1_ready", {31'd0, r1_ready}, 32'd1);
        step(); r1_valid = 1'b0;
        chk("mul_opc_start", {30'd0, alu_op_code}, 32'd2);
        step();
        chk("mul_byte0", {24'd0, alu_inbus}, 32'h0C);
        step();
        chk("mul_byte1", {24'd0, alu_inbus}, 32'h0B);
        step();
        chk("mul_opc_wait", {30'd0, alu_op_code}, 32'd2);
        alu_outbus = 8'h00;
        step();
        alu_outbus = 8'h84; alu_end = 1'b1;
        step();
        alu_end = 1'b0;
        chk("mul_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("mul_result", {16'd0, rsp_result}, 32'h0084);
        chk("mul_id", {31'd0, rsp_id}, 32'd1);
        step();

        // r0 div 0x0064 / 7 -> rem 02, quo 0E
        r0_valid = 1'b1; r0_op = 2'd3; r0_x = 16'h0064; r0_y = 8'h07;
        #1;
        chk("div_r0_ready", {31'd0, r0_ready}, 32'd1);
        step(); r0_valid = 1'b0;
        chk("div_opc", {30'd0, alu_op_code}, 32'd3);
        step();
        chk("div_byte0", {24'd0, alu_inbus}, 32'h00);
        step();
        chk("div_byte1", {24'd0, alu_inbus}, 32'h64);
        step();
        chk("div_byte2", {24'd0, alu_inbus}, 32'h07);
        step();
        chk("div_wait_inbus", {24'd0, alu_inbus}, 32'h00);
        alu_outbus = 8'h02;
        step();
        alu_outbus = 8'h0E; alu_end = 1'b1;
        step();
        alu_end = 1'b0;
        chk("div_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("div_result", {16'd0, rsp_result}, 32'h020E);
        chk("div_id", {31'd0, rsp_id}, 32'd0);
        chk("div_err", {31'd0, rsp_error}, 32'd0);
        step();

        // r1 divide by zero: immediate error response, ALU untouched
        r1_valid = 1'b1; r1_op = 2'd3; r1_x = 16'h1234; r1_y = 8'h00;
        #1;
        chk("dz_r1_ready", {31'd0, r1_ready}, 32'd1);
        step(); r1_valid = 1'b0;
        chk("dz_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("dz_err", {31'd0, rsp_error}, 32'd1);
        chk("dz_result", {16'd0, rsp_result}, 32'hFFFF);
        chk("dz_id", {31'd0, rsp_id}, 32'd1);
        chk("dz_begin", {31'd0, alu_begin}, 32'd0);
        step();
        chk("dz_rsp_once", {31'd0, rsp_valid}, 32'd0);
        chk("dz_begin2", {31'd0, alu_begin}, 32'd0);

        // Both requesters valid continuously: grants alternate 0,1,0,1
        alu_outbus = 8'h5A; alu_end = 1'b1;
        r0_valid = 1'b1; r0_op = 2'd0; r0_x = 16'h0001; r0_y = 8'h01;
        r1_valid = 1'b1; r1_op = 2'd1; r1_x = 16'h0002; r1_y = 8'h01;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!(r0_ready || r1_ready) && (n < 10)) begin
                step();
                n++;
            end
            chk("rr_grant", {30'd0, r1_ready, r0_ready}, ((i % 2) == 1) ? 32'd2 : 32'd1);
            step();
            n = 0;
            while (!rsp_valid && (n < 20)) begin
                step();
                n++;
            end
            chk("rr_rspv", {31'd0, rsp_valid}, 32'd1);
            chk("rr_id", {31'd0, rsp_id}, (i % 2));
            chk("rr_result", {16'd0, rsp_result}, 32'h005A);
            step();
        end
        r0_valid = 1'b0; r1_valid = 1'b0; alu_end = 1'b0;
        step();

`ifdef ALU_SCHED_TIMEOUT_EN
        // No END: abort after TIMEOUT_CYCLES WAIT cycles
        r0_valid = 1'b1; r0_op = 2'd0; r0_x = 16'h0005; r0_y = 8'h03;
        #1;
        chk("to_r0_ready", {31'd0, r0_ready}, 32'd1);
        step(); r0_valid = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            step();
            seen = seen | rsp_valid | alu_reset;
        end
        chk("to_early", {31'd0, seen}, 32'd0);
        step();
        chk("to_rspv", {31'd0, rsp_valid}, 32'd1);
        chk("to_err", {31'd0, rsp_error}, 32'd1);
        chk("to_result", {16'd0, rsp_result}, 32'h0000);
        chk("to_alurst", {31'd0, alu_reset}, 32'd1);
        step();
        chk("to_alurst_pulse", {31'd0, alu_reset}, 32'd0);
`endif

        // Asynchronous reset in the middle of LOAD
        r0_valid = 1'b1; r0_op = 2'd0; r0_x = 16'h0005; r0_y = 8'h03;
        #1;
        chk("ar_r0_ready", {31'd0, r0_ready}, 32'd1);
        step(); r0_valid = 1'b0;
        step();
        chk("ar_byte0", {24'd0, alu_inbus}, 32'h05);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("ar");
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            step();
            seen = seen | rsp_valid | alu_begin;
        end
        chk("ar_no_rsp", {31'd0, seen}, 32'd0);
        r0_valid = 1'b1; r1_valid = 1'b1;
        #1;
        chk("ar_ptr_r0", {30'd0, r1_ready, r0_ready}, 32'd1);
        r0_valid = 1'b0; r1_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
